wps_frame_player: RTL and testbench
===================================

// Module: wps_frame_player
// PURPOSE
//  Single-clock playback engine for binary (1 bit/pixel) pattern frames.
//  - Polls a 256-bit config word at on-chip memory address 0.
//  - When play is requested, streams the frames from DDR3 over an Avalon-MM-style port.
//  - Expands each bit to a 24-bit pixel and emits de/h_sync/v_sync markers.
//  - Writes a done flag back to the config word when playback finishes.
// PARAMETERS
//  PIX_ON      24'hFFFFFF  pixel value output for bit=1
//  PIX_OFF     24'h000000  pixel value output for bit=0
//  DDR_AW      22          DDR3 word-address width
//  OCM_AW      13          on-chip memory address width
// PORTS
//  mem_clk                 in   1    sole clock, all logic rising-edge
//  mem_rst                 in   1    reset, synchronous, active-high
//  ddr3_emif_ready         in   1    1 = read command accepted this cycle
//  ddr3_emif_read_data     in   256  read data
//  ddr3_emif_rddata_valid  in   1    read data valid (latency unspecified, in order)
//  ddr3_emif_read          out  1    read command
//  ddr3_emif_write         out  1    tied 0
//  ddr3_emif_addr          out  22   256-bit word address
//  ddr3_emif_write_data    out  256  tied 0
//  ddr3_emif_byte_enable   out  32   tied all-ones
//  ddr3_emif_burst_count   out  5    tied 1
//  onchip_mem_chip_select  out  1    1 during any on-chip access
//  onchip_mem_clk_ena      out  1    tied 1
//  onchip_mem_addr         out  13   always 0 (config word)
//  onchip_mem_byte_enable  out  32   all-ones
//  onchip_mem_write_data   out  256  config write-back data
//  onchip_mem_write        out  1    write strobe, 1 cycle
//  onchip_mem_read_data    in   256  valid exactly 2 cycles after the address is driven
//  h_sync_out              out  1    1-cycle pulse with first pixel of each line
//  v_sync_out              out  1    1-cycle pulse with first pixel of each frame
//  de_out                  out  1    pixel valid
//  pix_data_out            out  24   pixel
// BEHAVIOUR
//  Config word fields:
//  - [255] start_play, [254] pattern_source, [247] play_done
//  - [223:192] to_send_frame, [191:160] one_frame_byte
//  - [159:144] h_pix, [143:128] v_line
//  - [127:96] total_byte, [95:64] start_addr; other bits reserved
//  Reset: all outputs 0 except the tied constants; state IDLE; counters cleared. Reset mid-play aborts at once with no write-back.
//  States:
//  - IDLE: drive addr 0 with chip_select for 1 cycle -> CFG_WAIT.
//  - CFG_WAIT: wait 2 cycles, latch the word -> CHECK.
//  - CHECK: proceed only if start_play=1 and play_done=0, else back to IDLE (re-poll).
//    pattern_source=1 -> GEN; else -> RD_REQ, or -> WB if total_byte<32 or to_send_frame=0.
//  - RD_REQ: read=1 with addr = start_addr[21:0] + word_idx. Hold read and addr stable while ready=0; leave on read&&ready -> RD_WAIT.
//  - RD_WAIT: on rddata_valid load the 256-bit shift register -> SHIFT.
//  - SHIFT: one pixel per cycle, MSB first, de_out=1, 256 cycles.
//    Then word_idx+1; if word_idx = total_byte/32 -> WB, else -> RD_REQ.
//    At most one read outstanding; de_out is low in the gaps.
//  - GEN: no DDR access. Pixel bit = h_cnt[4]^v_cnt[4]; de continuous for to_send_frame frames -> WB.
//  - WB: write the latched word with [255]=0 and [247]=1, write=1 for 1 cycle -> IDLE.
//  Pixel counters:
//  - h_cnt runs 0..h_pix-1, then v_cnt advances 0..v_line-1; both wrap.
//  - Counters advance only when de_out=1.
//  - h_sync_out=de&&h_cnt==0; v_sync_out=de&&h_cnt==0&&v_cnt==0.
//  - Pixel outputs registered: 1 cycle after the bit is shifted.
//  Arithmetic: word_idx 27 bits; DDR address sum truncates to 22 bits and wraps.
//  No check that frame size and resolution agree; the counters wrap independently.
// TESTING
//  - Cfg 1920x1080, one_frame_byte=259200, frames=2, start_addr=8, DDR latency 13.
//    -> first read addr 8, 16200 reads, last addr 16207, then one write with [247]=1.
//  - DDR word 0x000102..1f at addr 8 -> pixels 0..14 = PIX_OFF, pixel 15 = PIX_ON.
//    First pixel has v_sync=h_sync=1.
//  - Pixel count per line: h_sync pulse every 1920 de cycles; v_sync every 2073600 de cycles.
//  - ready held 0 for 5 cycles during RD_REQ -> read/addr stable throughout, exactly one command accepted.
//  - start_play=0 or play_done=1 -> no DDR reads, repeated config polls at addr 0.
//  - pattern_source=1, 32x32, 1 frame -> de for 1024 consecutive cycles, checkerboard, zero DDR reads.
//  - mem_rst asserted during SHIFT -> next cycle de/read/write=0; after release, config re-polled.

Source files
------------

// File: rtl/wps_frame_player.sv
// wps_frame_player: polls a 256-bit config word, streams 1 bpp frames
// from DDR3 (or a generated checkerboard) as 24-bit pixels, then writes
// a done flag back to the config word.
// Ports: mem_clk/mem_rst (sync, active-high); ddr3_emif_* Avalon-MM read
// master; onchip_mem_* config word access at address 0; de_out,
// h_sync_out, v_sync_out, pix_data_out registered pixel stream.
module wps_frame_player #(
    parameter logic [23:0] PIX_ON  = 24'hFFFFFF,
    parameter logic [23:0] PIX_OFF = 24'h000000,
    parameter int          DDR_AW  = 22,
    parameter int          OCM_AW  = 13
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    input  logic              ddr3_emif_ready,
    input  logic [255:0]      ddr3_emif_read_data,
    input  logic              ddr3_emif_rddata_valid,
    output logic              ddr3_emif_read,
    output logic              ddr3_emif_write,
    output logic [DDR_AW-1:0] ddr3_emif_addr,
    output logic [255:0]      ddr3_emif_write_data,
    output logic [31:0]       ddr3_emif_byte_enable,
    output logic [4:0]        ddr3_emif_burst_count,
    output logic              onchip_mem_chip_select,
    output logic              onchip_mem_clk_ena,
    output logic [OCM_AW-1:0] onchip_mem_addr,
    output logic [31:0]       onchip_mem_byte_enable,
    output logic [255:0]      onchip_mem_write_data,
    output logic              onchip_mem_write,
    input  logic [255:0]      onchip_mem_read_data,
    output logic              h_sync_out,
    output logic              v_sync_out,
    output logic              de_out,
    output logic [23:0]       pix_data_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG_WAIT, S_CHECK, S_RD_REQ,
        S_RD_WAIT, S_SHIFT, S_GEN, S_WB
    } state_t;

    state_t        state_q, state_d;
    logic [255:0]  cfg_q, cfg_d;
    logic [255:0]  sreg_q, sreg_d;
    logic          cfg_wait_q, cfg_wait_d;
    logic [7:0]    bit_cnt_q, bit_cnt_d;
    logic [26:0]   word_idx_q, word_idx_d;
    logic [15:0]   h_cnt_q, h_cnt_d;
    logic [15:0]   v_cnt_q, v_cnt_d;
    logic [31:0]   frame_cnt_q, frame_cnt_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic [23:0]   pix_q, pix_d;

    logic          pix_vld;
    logic          pix_bit;
    logic          h_last;
    logic          v_last;

    // Config word fields
    logic          start_play;
    logic          pattern_src;
    logic          play_done;
    logic [31:0]   to_send_frame;
    logic [15:0]   h_pix;
    logic [15:0]   v_line;
    logic [26:0]   total_words;

    assign start_play    = cfg_q[255];
    assign pattern_src   = cfg_q[254];
    assign play_done     = cfg_q[247];
    assign to_send_frame = cfg_q[223:192];
    assign h_pix         = cfg_q[159:144];
    assign v_line        = cfg_q[143:128];
    // total_byte/32; zero also means total_byte < 32
    assign total_words   = cfg_q[127:101];

    assign h_last = (h_cnt_q == h_pix - 16'd1);
    assign v_last = (v_cnt_q == v_line - 16'd1);

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        sreg_d      = sreg_q;
        cfg_wait_d  = cfg_wait_q;
        bit_cnt_d   = bit_cnt_q;
        word_idx_d  = word_idx_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pix_vld     = 1'b0;
        pix_bit     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cfg_wait_d = 1'b0;
                state_d    = S_CFG_WAIT;
            end
            S_CFG_WAIT: begin
                // Read data lands two cycles after the IDLE address cycle
                cfg_wait_d = 1'b1;
                if (cfg_wait_q) begin
                    cfg_d   = onchip_mem_read_data;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (start_play && !play_done) begin
                    word_idx_d  = '0;
                    h_cnt_d     = '0;
                    v_cnt_d     = '0;
                    frame_cnt_d = '0;
                    if (pattern_src)
                        state_d = S_GEN;
                    else if (total_words == '0 || to_send_frame == '0)
                        state_d = S_WB;
                    else
                        state_d = S_RD_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (ddr3_emif_ready)
                    state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (ddr3_emif_rddata_valid) begin
                    sreg_d    = ddr3_emif_read_data;
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                pix_vld   = 1'b1;
                pix_bit   = sreg_q[255];
                sreg_d    = {sreg_q[254:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 8'd1;
                if (bit_cnt_q == 8'd255) begin
                    word_idx_d = word_idx_q + 27'd1;
                    state_d = (word_idx_d == total_words) ? S_WB : S_RD_REQ;
                end
            end
            S_GEN: begin
                pix_vld = 1'b1;
                pix_bit = h_cnt_q[4] ^ v_cnt_q[4];
                if (h_last && v_last) begin
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    if (frame_cnt_d >= to_send_frame)
                        state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Raster counters follow the pixel stream, independent of frame size
        if (pix_vld) begin
            if (h_last) begin
                h_cnt_d = '0;
                v_cnt_d = v_last ? 16'd0 : v_cnt_q + 16'd1;
            end else begin
                h_cnt_d = h_cnt_q + 16'd1;
            end
        end

        de_d  = pix_vld;
        hs_d  = pix_vld && (h_cnt_q == '0);
        vs_d  = pix_vld && (h_cnt_q == '0) && (v_cnt_q == '0);
        pix_d = pix_vld ? (pix_bit ? PIX_ON : PIX_OFF) : 24'd0;
    end

    always_ff @(posedge mem_clk) begin
        if (mem_rst) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            sreg_q      <= '0;
            cfg_wait_q  <= 1'b0;
            bit_cnt_q   <= '0;
            word_idx_q  <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            de_q        <= 1'b0;
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            sreg_q      <= sreg_d;
            cfg_wait_q  <= cfg_wait_d;
            bit_cnt_q   <= bit_cnt_d;
            word_idx_q  <= word_idx_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            pix_q       <= pix_d;
        end
    end

    assign ddr3_emif_read  = !mem_rst && (state_q == S_RD_REQ);
    // Address is a function of state only, so it holds while ready=0
    assign ddr3_emif_addr  = (state_q == S_RD_REQ) ?
                             cfg_q[64 +: DDR_AW] + word_idx_q[DDR_AW-1:0] :
                             '0;
    assign ddr3_emif_write       = 1'b0;
    assign ddr3_emif_write_data  = '0;
    assign ddr3_emif_byte_enable = '1;
    assign ddr3_emif_burst_count = 5'd1;

    assign onchip_mem_chip_select = !mem_rst &&
                                    (state_q == S_IDLE || state_q == S_WB);
    assign onchip_mem_write       = !mem_rst && (state_q == S_WB);
    assign onchip_mem_write_data  = (state_q == S_WB) ?
                                    {1'b0, cfg_q[254:248], 1'b1, cfg_q[246:0]} :
                                    '0;
    assign onchip_mem_clk_ena      = 1'b1;
    assign onchip_mem_addr         = '0;
    assign onchip_mem_byte_enable  = '1;

    assign de_out       = de_q;
    assign h_sync_out   = hs_q;
    assign v_sync_out   = vs_q;
    assign pix_data_out = pix_q;

endmodule

// File: tb/tb_wps_frame_player.sv
// tb_wps_frame_player: directed bench for wps_frame_player with a
// 2-cycle on-chip memory model and a fixed-latency DDR3 read model.
module tb_wps_frame_player;

    localparam int LAT = 13;
    localparam logic [23:0] ON  = 24'hFFFFFF;
    localparam logic [23:0] OFF = 24'h000000;

    logic         clk = 1'b0;
    logic         mem_rst = 1'b1;
    logic         ddr_ready = 1'b1;
    logic [255:0] ddr_rdata = '0;
    logic         ddr_valid = 1'b0;
    logic         ddr_read;
    logic         ddr_write;
    logic [21:0]  ddr_addr;
    logic [255:0] ddr_wdata;
    logic [31:0]  ddr_be;
    logic [4:0]   ddr_burst;
    logic         ocm_cs;
    logic         ocm_clk_ena;
    logic [12:0]  ocm_addr;
    logic [31:0]  ocm_be;
    logic [255:0] ocm_wdata;
    logic         ocm_write;
    logic [255:0] ocm_rdata = '0;
    logic         hs, vs, de;
    logic [23:0]  pix;

    // Bench state
    logic [255:0] cfg_mem = '0;
    logic [255:0] ocm_p1 = '0;
    logic [255:0] ocm_p2 = '0;
    logic [255:0] wr_data = '0;
    logic [21:0]  pend_addr = '0;
    int lat_cnt = 0;
    int n_reads = 0;
    int wr_cnt = 0;
    int poll_cnt = 0;
    int bad_oaddr = 0;
    int de_rises = 0;
    logic prev_de = 1'b0;
    logic [21:0] addr_log[$];
    logic [23:0] pix_log[$];
    logic        hs_log[$];
    logic        vs_log[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wps_frame_player dut (
        .mem_clk                (clk),
        .mem_rst                (mem_rst),
        .ddr3_emif_ready        (ddr_ready),
        .ddr3_emif_read_data    (ddr_rdata),
        .ddr3_emif_rddata_valid (ddr_valid),
        .ddr3_emif_read         (ddr_read),
        .ddr3_emif_write        (ddr_write),
        .ddr3_emif_addr         (ddr_addr),
        .ddr3_emif_write_data   (ddr_wdata),
        .ddr3_emif_byte_enable  (ddr_be),
        .ddr3_emif_burst_count  (ddr_burst),
        .onchip_mem_chip_select (ocm_cs),
        .onchip_mem_clk_ena     (ocm_clk_ena),
        .onchip_mem_addr        (ocm_addr),
        .onchip_mem_byte_enable (ocm_be),
        .onchip_mem_write_data  (ocm_wdata),
        .onchip_mem_write       (ocm_write),
        .onchip_mem_read_data   (ocm_rdata),
        .h_sync_out             (hs),
        .v_sync_out             (vs),
        .de_out                 (de),
        .pix_data_out           (pix)
    );

    function automatic logic [255:0] ddr_word(input logic [21:0] a);
        logic [255:0] w;
        if (a == 22'd8)
            w = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        else
            w = {8{10'h2A5, a}};
        return w;
    endfunction

    function automatic logic [255:0] mk_cfg(
        input logic        start, input logic src, input logic done,
        input logic [31:0] frames, input logic [15:0] h, input logic [15:0] v,
        input logic [31:0] total, input logic [31:0] saddr);
        logic [255:0] c;
        c = '0;
        c[255] = start;
        c[254] = src;
        c[247] = done;
        c[223:192] = frames;
        c[191:160] = 32'(h) * 32'(v) / 8;
        c[159:144] = h;
        c[143:128] = v;
        c[127:96] = total;
        c[95:64] = saddr;
        c[7:0] = 8'h5A;
        return c;
    endfunction

    // Memory models and stream monitor, all on the falling edge
    always @(negedge clk) begin
        ddr_valid = 1'b0;
        if (mem_rst) begin
            lat_cnt = 0;
        end else begin
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    ddr_valid = 1'b1;
                    ddr_rdata = ddr_word(pend_addr);
                end
            end
            if (ddr_read && ddr_ready) begin
                lat_cnt = LAT;
                pend_addr = ddr_addr;
                n_reads++;
                addr_log.push_back(ddr_addr);
            end
        end
        ocm_rdata = ocm_p2;
        ocm_p2 = ocm_p1;
        ocm_p1 = (ocm_cs && !ocm_write) ? cfg_mem : '0;
        if (ocm_write) begin
            cfg_mem = ocm_wdata;
            wr_data = ocm_wdata;
            wr_cnt++;
        end
        if (ocm_cs && !ocm_write) poll_cnt++;
        if (ocm_cs && ocm_addr != 13'd0) bad_oaddr++;
        if (de) begin
            pix_log.push_back(pix);
            hs_log.push_back(hs);
            vs_log.push_back(vs);
        end
        if (de && !prev_de) de_rises++;
        prev_de = de;
    end

    task automatic start_run(input logic [255:0] c);
        mem_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cfg_mem = c;
        n_reads = 0;
        wr_cnt = 0;
        poll_cnt = 0;
        bad_oaddr = 0;
        de_rises = 0;
        addr_log.delete();
        pix_log.delete();
        hs_log.delete();
        vs_log.delete();
        mem_rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({de, hs, vs, pix} !== 27'd0) begin
            errors++;
            $display("FAIL reset_pix: got de=%b hs=%b vs=%b pix=%h want 0", de, hs, vs, pix);
        end
        checks++;
        if ({ddr_read, ddr_write, ocm_cs, ocm_write} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: got rd=%b wr=%b cs=%b ow=%b want 0",
                     ddr_read, ddr_write, ocm_cs, ocm_write);
        end
        checks++;
        if (ddr_burst !== 5'd1 || ddr_be !== '1 || ocm_clk_ena !== 1'b1 ||
            ddr_wdata !== '0 || ocm_be !== '1) begin
            errors++;
            $display("FAIL reset_ties: got burst=%0d be=%h ena=%b want 1/ones/1",
                     ddr_burst, ddr_be, ocm_clk_ena);
        end
        start_run(mk_cfg(1'b0, 1'b0, 1'b0, 32'd1, 16'd16, 16'd32, 32'd96, 32'd8));
        #1;
        checks++;
        if (ocm_cs !== 1'b1 || ocm_addr !== 13'd0) begin
            errors++;
            $display("FAIL first_poll: got cs=%b addr=%h want 1/0", ocm_cs, ocm_addr);
        end
    endtask

    task automatic test_idle_poll(input logic start, input logic done, input string nm);
        start_run(mk_cfg(start, 1'b0, done, 32'd1, 16'd16, 16'd32, 32'd96, 32'd8));
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (n_reads != 0 || wr_cnt != 0 || pix_log.size() != 0) begin
            errors++;
            $display("FAIL %s_quiet: got reads=%0d writes=%0d de=%0d want 0/0/0",
                     nm, n_reads, wr_cnt, pix_log.size());
        end
        checks++;
        if (poll_cnt < 9 || poll_cnt > 11 || bad_oaddr != 0) begin
            errors++;
            $display("FAIL %s_polls: got polls=%0d badaddr=%0d want 9..11/0",
                     nm, poll_cnt, bad_oaddr);
        end
    endtask

    task automatic test_ddr_play();
        logic [255:0] c;
        logic [255:0] w;
        logic [255:0] exp_wb;
        logic [23:0]  exp_pix;
        int bad;
        int first_bad;
        c = mk_cfg(1'b1, 1'b0, 1'b0, 32'd1, 16'd16, 16'd32, 32'd96, 32'd8);
        start_run(c);
        for (int i = 0; i < 3000 && wr_cnt == 0; i++) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != 1) begin
            errors++;
            $display("FAIL ddr_done: got writes=%0d want 1", wr_cnt);
        end
        checks++;
        if (n_reads != 3) begin
            errors++;
            $display("FAIL ddr_reads: got %0d want 3", n_reads);
        end
        for (int k = 0; k < 3 && k < addr_log.size(); k++) begin
            checks++;
            if (addr_log[k] !== 22'(8 + k)) begin
                errors++;
                $display("FAIL ddr_addr%0d: got %h want %h", k, addr_log[k], 22'(8 + k));
            end
        end
        checks++;
        if (pix_log.size() != 768) begin
            errors++;
            $display("FAIL ddr_de_count: got %0d want 768", pix_log.size());
        end
        if (pix_log.size() >= 16) begin
            checks++;
            if (pix_log[15] !== ON || pix_log[14] !== OFF || pix_log[0] !== OFF) begin
                errors++;
                $display("FAIL first_word: got p0=%h p14=%h p15=%h want 0/0/ffffff",
                         pix_log[0], pix_log[14], pix_log[15]);
            end
            checks++;
            if (hs_log[0] !== 1'b1 || vs_log[0] !== 1'b1) begin
                errors++;
                $display("FAIL first_sync: got hs=%b vs=%b want 1/1", hs_log[0], vs_log[0]);
            end
        end
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < pix_log.size(); i++) begin
            w = ddr_word(22'(8 + i / 256));
            exp_pix = w[255 - (i % 256)] ? ON : OFF;
            if (pix_log[i] !== exp_pix || hs_log[i] !== (i % 16 == 0) ||
                vs_log[i] !== (i % 512 == 0)) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ddr_stream: got %0d bad pixels (first %0d) want 0", bad, first_bad);
        end
        exp_wb = c;
        exp_wb[255] = 1'b0;
        exp_wb[247] = 1'b1;
        checks++;
        if (wr_data !== exp_wb) begin
            errors++;
            $display("FAIL ddr_writeback: got %h want %h", wr_data, exp_wb);
        end
    endtask

    task automatic test_addr_wrap();
        start_run(mk_cfg(1'b1, 1'b0, 1'b0, 32'd1, 16'd16, 16'd32, 32'd64, 32'hFFFF_FFFF));
        for (int i = 0; i < 2000 && wr_cnt == 0; i++) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != 1 || addr_log.size() != 2) begin
            errors++;
            $display("FAIL wrap_count: got writes=%0d reads=%0d want 1/2", wr_cnt, addr_log.size());
        end else begin
            checks++;
            if (addr_log[0] !== 22'h3FFFFF || addr_log[1] !== 22'h000000) begin
                errors++;
                $display("FAIL wrap_addr: got %h,%h want 3fffff,000000",
                         addr_log[0], addr_log[1]);
            end
        end
    endtask

    task automatic test_no_data(input logic [31:0] frames, input logic [31:0] total,
                                input string nm);
        start_run(mk_cfg(1'b1, 1'b0, 1'b0, frames, 16'd16, 16'd32, total, 32'd8));
        for (int i = 0; i < 50 && wr_cnt == 0; i++) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != 1 || n_reads != 0 || pix_log.size() != 0 || wr_data[247] !== 1'b1) begin
            errors++;
            $display("FAIL %s: got writes=%0d reads=%0d de=%0d done=%b want 1/0/0/1",
                     nm, wr_cnt, n_reads, pix_log.size(), wr_data[247]);
        end
    endtask

    task automatic test_stall();
        ddr_ready = 1'b0;
        start_run(mk_cfg(1'b1, 1'b0, 1'b0, 32'd1, 16'd16, 16'd32, 32'd32, 32'h40));
        for (int i = 0; i < 50 && ddr_read !== 1'b1; i++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ddr_read !== 1'b1 || ddr_addr !== 22'h40) begin
                errors++;
                $display("FAIL stall_hold%0d: got rd=%b addr=%h want 1/40", k, ddr_read, ddr_addr);
            end
            @(negedge clk);
        end
        checks++;
        if (n_reads != 0) begin
            errors++;
            $display("FAIL stall_accept: got %0d accepted want 0", n_reads);
        end
        @(posedge clk);
        #1;
        ddr_ready = 1'b1;
        for (int i = 0; i < 1000 && wr_cnt == 0; i++) @(posedge clk);
        #1;
        checks++;
        if (n_reads != 1 || wr_cnt != 1 || pix_log.size() != 256) begin
            errors++;
            $display("FAIL stall_result: got reads=%0d writes=%0d de=%0d want 1/1/256",
                     n_reads, wr_cnt, pix_log.size());
        end
    endtask

    task automatic test_gen();
        int bad;
        int hs_n;
        logic b;
        start_run(mk_cfg(1'b1, 1'b1, 1'b0, 32'd1, 16'd32, 16'd32, 32'd0, 32'd8));
        for (int i = 0; i < 2000 && wr_cnt == 0; i++) @(posedge clk);
        #1;
        checks++;
        if (wr_cnt != 1 || n_reads != 0) begin
            errors++;
            $display("FAIL gen_done: got writes=%0d reads=%0d want 1/0", wr_cnt, n_reads);
        end
        checks++;
        if (pix_log.size() != 1024 || de_rises != 1) begin
            errors++;
            $display("FAIL gen_de: got count=%0d bursts=%0d want 1024/1",
                     pix_log.size(), de_rises);
        end
        bad = 0;
        hs_n = 0;
        for (int i = 0; i < pix_log.size(); i++) begin
            b = ((i % 32) / 16 != 0) ^ ((i / 32) % 32 / 16 != 0);
            if (pix_log[i] !== (b ? ON : OFF)) bad++;
            if (vs_log[i] !== (i == 0)) bad++;
            if (hs_log[i]) hs_n++;
        end
        checks++;
        if (bad != 0 || hs_n != 32) begin
            errors++;
            $display("FAIL gen_pattern: got bad=%0d hsyncs=%0d want 0/32", bad, hs_n);
        end
    endtask

    task automatic test_reset_mid();
        int reads_before;
        start_run(mk_cfg(1'b1, 1'b0, 1'b0, 32'd1, 16'd16, 16'd32, 32'd128, 32'd8));
        for (int i = 0; i < 200 && de !== 1'b1; i++) @(posedge clk);
        #1;
        checks++;
        if (de !== 1'b1) begin
            errors++;
            $display("FAIL mid_start: got de=%b want 1", de);
        end
        mem_rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (de !== 1'b0 || ddr_read !== 1'b0 || ocm_write !== 1'b0 || hs !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: got de=%b rd=%b wr=%b hs=%b want 0", de, ddr_read,
                     ocm_write, hs);
        end
        cfg_mem[255] = 1'b0;
        reads_before = n_reads;
        poll_cnt = 0;
        @(posedge clk);
        #1;
        mem_rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (poll_cnt < 2 || wr_cnt != 0 || n_reads != reads_before) begin
            errors++;
            $display("FAIL mid_repoll: got polls=%0d writes=%0d reads=%0d want >=2/0/%0d",
                     poll_cnt, wr_cnt, n_reads, reads_before);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_poll(1'b0, 1'b0, "no_start");
        test_idle_poll(1'b1, 1'b1, "already_done");
        test_ddr_play();
        test_addr_wrap();
        test_no_data(32'd1, 32'd31, "short_total");
        test_no_data(32'd0, 32'd64, "zero_frames");
        test_stall();
        test_gen();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
